axi_datamover_cmd_arbiter: RTL and testbench

Multi-stream command and status front end for the AXI DataMover, replacing the single-outstanding stream master.
- Each of NUM_STREAMS channels owns a register-programmed command FIFO, where an addr+size pair becomes one entry, and a status FIFO.
- A round-robin arbiter issues commands with up to MAX_OUTSTANDING in flight per stream.
- Returning status beats are routed to their stream by tag.
- Sits between the AXI-lite settings bus (set/get) and the DataMover CMD/STS ports.

---
 rtl/axi_datamover_cmd_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_axi_datamover_cmd_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_datamover_cmd_arbiter.sv
// Multi-stream DataMover command/status front end: per-stream command and status FIFOs,
// round-robin issue with a per-stream in-flight limit, and tag-routed status return.
module axi_datamover_cmd_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_STREAMS     = 4,
  parameter int BTT_WIDTH       = 23,
  parameter int CMD_DEPTH       = 16,
  parameter int STS_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PAGEWIDTH       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    M_AXIS_CMD_TVALID,
  input  logic                    M_AXIS_CMD_TREADY,
  output logic [ADDR_WIDTH+39:0]  M_AXIS_CMD_TDATA,
  input  logic                    S_AXIS_STS_TVALID,
  output logic                    S_AXIS_STS_TREADY,
  input  logic [7:0]              S_AXIS_STS_TDATA,
  input  logic [DATA_WIDTH-1:0]   set_data,
  input  logic [ADDR_WIDTH-1:0]   set_addr,
  input  logic                    set_stb,
  output logic [DATA_WIDTH-1:0]   get_data,
  input  logic [ADDR_WIDTH-1:0]   get_addr,
  input  logic                    get_stb,
  input  logic [NUM_STREAMS-1:0]  stream_valid,
  output logic [NUM_STREAMS-1:0]  irq
);
  localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int QW = $clog2(STS_DEPTH);
  localparam int EW = ADDR_WIDTH + BTT_WIDTH;
  localparam int RW = PAGEWIDTH - 5;
  localparam logic [31:0] NS       = 32'(NUM_STREAMS);
  localparam logic [3:0]  MAXO     = 4'(MAX_OUTSTANDING);
  localparam logic [CW:0] CMD_FULL = (CW+1)'(CMD_DEPTH);
  localparam logic [QW:0] STS_FULL = (QW+1)'(STS_DEPTH);

  logic [EW-1:0]         cmd_mem [NUM_STREAMS][CMD_DEPTH];
  logic [7:0]            sts_mem [NUM_STREAMS][STS_DEPTH];
  logic [CW-1:0]         cmd_wp [NUM_STREAMS];
  logic [CW-1:0]         cmd_rp [NUM_STREAMS];
  logic [CW:0]           cmd_cnt [NUM_STREAMS];
  logic [QW-1:0]         sts_wp [NUM_STREAMS];
  logic [QW-1:0]         sts_rp [NUM_STREAMS];
  logic [QW:0]           sts_cnt [NUM_STREAMS];
  logic [3:0]            outst [NUM_STREAMS];
  logic [ADDR_WIDTH-1:0] stage [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] en, ovf, stserr;
  logic [NUM_STREAMS-1:0] elig, cmd_pop, cmd_push, clr, sts_push, sts_pop, sts_full, sts_empty;

  logic [RW-1:0] wr_s, rd_s;
  logic [2:0]    wr_r, rd_r;
  logic          wr_ok, rd_ok;
  logic [SW-1:0] wr_sel, rd_sel, last, gsel;
  logic          grant, load, out_valid;
  logic [ADDR_WIDTH+39:0] out_data;
  logic [EW-1:0] cmd_head;
  logic [3:0]    sts_tag;
  logic          tag_ok, sts_hs, bad_tag;
  logic [31:0]   rd_word;
  logic          unused_bits;

  assign wr_s   = set_addr[PAGEWIDTH-1:5];
  assign wr_r   = set_addr[4:2];
  assign wr_ok  = set_stb && (32'(wr_s) < NS);
  assign wr_sel = wr_s[SW-1:0];
  assign rd_s   = get_addr[PAGEWIDTH-1:5];
  assign rd_r   = get_addr[4:2];
  assign rd_ok  = 32'(rd_s) < NS;
  assign rd_sel = rd_s[SW-1:0];
  assign unused_bits = &{1'b0, set_addr[ADDR_WIDTH-1:PAGEWIDTH], set_addr[1:0],
                         get_addr[ADDR_WIDTH-1:PAGEWIDTH], get_addr[1:0]};

  assign sts_tag = S_AXIS_STS_TDATA[3:0];
  assign tag_ok  = 32'(sts_tag) < NS;
  assign S_AXIS_STS_TREADY = tag_ok ? !sts_full[sts_tag[SW-1:0]] : 1'b1;
  assign sts_hs  = S_AXIS_STS_TVALID && S_AXIS_STS_TREADY;
  assign bad_tag = sts_hs && !tag_ok;

  assign load     = !out_valid || M_AXIS_CMD_TREADY;
  assign cmd_head = cmd_mem[gsel][cmd_rp[gsel]];

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      elig[i]      = en[i] && stream_valid[i] && (cmd_cnt[i] != '0) && (outst[i] < MAXO);
      sts_full[i]  = sts_cnt[i] == STS_FULL;
      sts_empty[i] = sts_cnt[i] == '0;
    end
  end

  // Scan from farthest to nearest so the nearest eligible stream after the last grant wins.
  always_comb begin
    logic [SW-1:0] idx;
    idx   = '0;
    grant = 1'b0;
    gsel  = last;
    for (int k = NUM_STREAMS; k >= 1; k--) begin
      idx = SW'((int'(last) + k) % NUM_STREAMS);
      if (load && elig[idx]) begin
        grant = 1'b1;
        gsel  = idx;
      end
    end
  end

  // A grant pop in the same cycle frees the slot, so a commit to a full FIFO still lands.
  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      cmd_pop[i]  = grant && (gsel == SW'(i));
      clr[i]      = wr_ok && (wr_r == 3'd0) && (wr_sel == SW'(i));
      cmd_push[i] = wr_ok && (wr_r == 3'd2) && (wr_sel == SW'(i)) &&
                    ((cmd_cnt[i] != CMD_FULL) || cmd_pop[i]);
      sts_push[i] = sts_hs && tag_ok && (sts_tag == 4'(i));
      sts_pop[i]  = wr_ok && (wr_r == 3'd3) && (wr_sel == SW'(i)) && !sts_empty[i];
    end
  end

  always_comb begin
    rd_word = 32'h1234_5678;
    if (rd_ok) begin
      case (rd_r)
        3'd0: rd_word = {16'hace1, 16'(rd_s)};
        3'd4: rd_word = {23'b0, sts_empty[rd_sel],
                         sts_empty[rd_sel] ? 8'h00 : sts_mem[rd_sel][sts_rp[rd_sel]]};
        3'd5: rd_word = {16'(cmd_cnt[rd_sel]), 16'(sts_cnt[rd_sel])};
        3'd7: rd_word = {ovf[rd_sel], stserr[rd_sel], 26'b0, outst[rd_sel]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (cmd_push[i]) cmd_mem[i][cmd_wp[i]] <= {stage[i], set_data[BTT_WIDTH-1:0]};
      if (sts_push[i]) sts_mem[i][sts_wp[i]] <= S_AXIS_STS_TDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      last      <= '0;
      get_data  <= '0;
      en        <= '0;
      ovf       <= '0;
      stserr    <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        cmd_wp[i]  <= '0;
        cmd_rp[i]  <= '0;
        cmd_cnt[i] <= '0;
        sts_wp[i]  <= '0;
        sts_rp[i]  <= '0;
        sts_cnt[i] <= '0;
        outst[i]   <= '0;
        stage[i]   <= '0;
      end
    end else begin
      if (load) out_valid <= grant;
      if (grant) begin
        out_data <= {4'b0, 4'(gsel), cmd_head[EW-1:BTT_WIDTH], 1'b0, 1'b1, 6'b0, 1'b0,
                     23'(cmd_head[BTT_WIDTH-1:0])};
        last     <= gsel;
      end
      if (get_stb) get_data <= DATA_WIDTH'(rd_word);
      for (int i = 0; i < NUM_STREAMS; i++) begin
        if (wr_ok && (wr_sel == SW'(i))) begin
          case (wr_r)
            3'd0: stage[i] <= '0;
            3'd1: stage[i] <= ADDR_WIDTH'(set_data);
            3'd6: en[i]    <= set_data[0];
            default: ;
          endcase
        end
        if (clr[i]) begin
          cmd_wp[i]  <= '0;
          cmd_rp[i]  <= '0;
          cmd_cnt[i] <= '0;
          ovf[i]     <= 1'b0;
          stserr[i]  <= 1'b0;
        end else begin
          if (cmd_push[i]) cmd_wp[i] <= cmd_wp[i] + CW'(1);
          if (cmd_pop[i])  cmd_rp[i] <= cmd_rp[i] + CW'(1);
          if (cmd_push[i] && !cmd_pop[i])      cmd_cnt[i] <= cmd_cnt[i] + (CW+1)'(1);
          else if (!cmd_push[i] && cmd_pop[i]) cmd_cnt[i] <= cmd_cnt[i] - (CW+1)'(1);
        end
        if (sts_push[i]) sts_wp[i] <= sts_wp[i] + QW'(1);
        if (sts_pop[i])  sts_rp[i] <= sts_rp[i] + QW'(1);
        if (sts_push[i] && !sts_pop[i])      sts_cnt[i] <= sts_cnt[i] + (QW+1)'(1);
        else if (!sts_push[i] && sts_pop[i]) sts_cnt[i] <= sts_cnt[i] - (QW+1)'(1);
        if (cmd_pop[i] && !sts_push[i])
          outst[i] <= outst[i] + 4'd1;
        else if (!cmd_pop[i] && sts_push[i] && (outst[i] != 4'd0))
          outst[i] <= outst[i] - 4'd1;
        if (wr_ok && (wr_r == 3'd2) && (wr_sel == SW'(i)) && !cmd_push[i]) ovf[i] <= 1'b1;
        if ((sts_push[i] && !cmd_pop[i] && (outst[i] == 4'd0)) || ((i == 0) && bad_tag))
          stserr[i] <= 1'b1;
      end
    end
  end

  assign M_AXIS_CMD_TVALID = out_valid;
  assign M_AXIS_CMD_TDATA  = out_data;
  assign irq               = ~sts_empty;

endmodule

// File: tb/tb_axi_datamover_cmd_arbiter.sv
// Scoreboard bench for axi_datamover_cmd_arbiter: stimulus queues expected command words and
// register reads; a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_datamover_cmd_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_tvalid, cmd_tready;
  logic [71:0] cmd_tdata;
  logic        sts_tvalid, sts_tready;
  logic [7:0]  sts_tdata;
  logic [31:0] set_data, set_addr, get_data, get_addr;
  logic        set_stb, get_stb;
  logic [3:0]  stream_valid, irq;

  int n_cmp = 0;
  int n_mis = 0;
  logic [71:0] exp_cmd[$];
  logic [31:0] exp_rd[$];
  string       rd_nm[$];
  logic        rd_d;

  always #5 clk = ~clk;

  axi_datamover_cmd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .M_AXIS_CMD_TVALID(cmd_tvalid), .M_AXIS_CMD_TREADY(cmd_tready), .M_AXIS_CMD_TDATA(cmd_tdata),
    .S_AXIS_STS_TVALID(sts_tvalid), .S_AXIS_STS_TREADY(sts_tready), .S_AXIS_STS_TDATA(sts_tdata),
    .set_data(set_data), .set_addr(set_addr), .set_stb(set_stb),
    .get_data(get_data), .get_addr(get_addr), .get_stb(get_stb),
    .stream_valid(stream_valid), .irq(irq)
  );

  function automatic logic [71:0] mk_cmd(int s, logic [31:0] a, logic [22:0] b);
    return {4'b0, 4'(s), a, 1'b0, 1'b1, 6'b0, 1'b0, b};
  endfunction

  function automatic logic [31:0] ra(int s, int r);
    return 32'((s * 8 + r) * 4);
  endfunction

  task automatic check(string nm, logic [71:0] act, logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_d <= 1'b0;
    else        rd_d <= get_stb;

  always @(negedge clk) begin
    if (rst_n && cmd_tvalid && cmd_tready) begin
      if (exp_cmd.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL cmd_unexpected: got %h expected none", cmd_tdata);
      end else check("cmd", cmd_tdata, exp_cmd.pop_front());
    end
    if (rd_d) begin
      if (exp_rd.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL rd_unexpected: got %h expected none", get_data);
      end else check(rd_nm.pop_front(), 72'(get_data), 72'(exp_rd.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(int s, int r, logic [31:0] d);
    set_addr = ra(s, r); set_data = d; set_stb = 1'b1;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic rd(string nm, int s, int r, logic [31:0] e);
    get_addr = ra(s, r); get_stb = 1'b1;
    exp_rd.push_back(e); rd_nm.push_back(nm);
    tick();
    get_stb = 1'b0;
  endtask

  task automatic commit(int s, logic [31:0] a, logic [31:0] b);
    wr(s, 1, a);
    wr(s, 2, b);
  endtask

  task automatic sts(logic [7:0] d);
    sts_tvalid = 1'b1; sts_tdata = d;
    tick();
    sts_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_tready = 1'b0; sts_tvalid = 1'b0; stream_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    n_mis++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_tready = 1'b0; sts_tvalid = 1'b0; sts_tdata = '0;
    set_data = '0; set_addr = '0; set_stb = 1'b0; get_addr = '0; get_stb = 1'b0;
    stream_valid = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_tvalid", 72'(cmd_tvalid), 72'd0);
    check("rst_tdata", cmd_tdata, 72'd0);
    check("rst_irq", 72'(irq), 72'd0);
    check("rst_get_data", 72'(get_data), 72'd0);
    rst_n = 1'b1;
    tick();
    rd("rst_id2", 2, 0, 32'hACE1_0002);
    rd("rst_unmapped_r1", 0, 1, 32'h1234_5678);
    rd("rst_unmapped_s4", 4, 0, 32'h1234_5678);
    rd("rst_fill0", 0, 5, 32'h0);
    rd("rst_head0", 0, 4, 32'h100);

    // single command on stream 1, held until accepted
    wr(1, 6, 1);
    stream_valid = 4'b0010;
    exp_cmd.push_back(mk_cmd(1, 32'h1000_0000, 23'h400));
    commit(1, 32'h1000_0000, 32'h400);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t1_hold_valid", 72'(cmd_tvalid), 72'd1);
      check("t1_hold_data", cmd_tdata, 72'h01_1000_0000_4000_0400);
      tick();
    end
    rd("t1_outst", 1, 7, 32'h1);
    cmd_tready = 1'b1;
    tick();
    wr(3, 6, 1);
    stream_valid = 4'b1010;
    exp_cmd.push_back(mk_cmd(3, 32'h3000_0000, 23'h30));
    commit(3, 32'h3000_0000, 32'h30);
    repeat (3) tick();

    // round robin 0,2,3 back to back, last grant was stream 3
    stream_valid = '0;
    wr(0, 6, 1);
    wr(2, 6, 1);
    for (int k = 0; k < 2; k++) begin
      commit(0, 32'h0000_A000 + 32'(k * 256), 32'h10 + 32'(k));
      commit(2, 32'h0002_A000 + 32'(k * 256), 32'h20 + 32'(k));
      commit(3, 32'h0003_A000 + 32'(k * 256), 32'h30 + 32'(k));
    end
    exp_cmd.push_back(mk_cmd(0, 32'h0000_A000, 23'h10));
    exp_cmd.push_back(mk_cmd(2, 32'h0002_A000, 23'h20));
    exp_cmd.push_back(mk_cmd(3, 32'h0003_A000, 23'h30));
    exp_cmd.push_back(mk_cmd(0, 32'h0000_A100, 23'h11));
    exp_cmd.push_back(mk_cmd(2, 32'h0002_A100, 23'h21));
    exp_cmd.push_back(mk_cmd(3, 32'h0003_A100, 23'h31));
    stream_valid = 4'b1101;
    repeat (7) tick();
    check("t2_back_to_back", 72'(exp_cmd.size()), 72'd0);
    check("t2_idle", 72'(cmd_tvalid), 72'd0);

    // outstanding limit on stream 0
    do_reset();
    wr(0, 6, 1);
    stream_valid = 4'b0001;
    cmd_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) exp_cmd.push_back(mk_cmd(0, 32'h2000_0000 + 32'(k * 256), 23'(16 + k)));
      commit(0, 32'h2000_0000 + 32'(k * 256), 32'(16 + k));
    end
    repeat (3) tick();
    check("t3_stall", 72'(cmd_tvalid), 72'd0);
    rd("t3_outst4", 0, 7, 32'h4);
    rd("t3_fill", 0, 5, 32'h0002_0000);
    exp_cmd.push_back(mk_cmd(0, 32'h2000_0400, 23'h14));
    sts(8'h00);
    repeat (3) tick();
    rd("t3_fill_after", 0, 5, 32'h0001_0001);
    rd("t3_outst_after", 0, 7, 32'h4);
    check("t3_irq", 72'(irq), 72'h1);

    // status routing by tag
    rd("t4_err0_pre", 0, 7, 32'h4);
    sts(8'h51);
    sts(8'h73);
    sts(8'h0F);
    tick();
    check("t4_irq", 72'(irq), 72'hB);
    rd("t4_head1", 1, 4, 32'h051);
    rd("t4_head3", 3, 4, 32'h073);
    rd("t4_stserr0", 0, 7, 32'h4000_0004);
    rd("t4_head0", 0, 4, 32'h000);
    wr(1, 3, 0);
    wr(3, 3, 0);
    check("t4_irq_popped", 72'(irq), 72'h1);
    rd("t4_head1_empty", 1, 4, 32'h100);
    wr(1, 3, 0);
    rd("t4_pop_empty", 1, 5, 32'h0);

    // overflow of a disabled stream, then clear
    wr(2, 6, 0);
    for (int k = 0; k < 17; k++) commit(2, 32'h5000_0000 + 32'(k), 32'(k));
    rd("t5_fill16", 2, 5, 32'h0010_0000);
    rd("t5_ovf", 2, 7, 32'h8000_0000);
    wr(2, 0, 0);
    rd("t5_fill_clr", 2, 5, 32'h0);
    rd("t5_ovf_clr", 2, 7, 32'h0);

    // async reset while a command is stalled
    wr(1, 6, 1);
    stream_valid = 4'b0010;
    cmd_tready = 1'b0;
    commit(1, 32'h6000_0000, 32'h60);
    tick();
    check("t6_pending", 72'(cmd_tvalid), 72'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_tvalid", 72'(cmd_tvalid), 72'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rd("t6_outst", 1, 7, 32'h0);
    rd("t6_fill1", 1, 5, 32'h0);
    rd("t6_fill0", 0, 5, 32'h0);
    check("t6_irq", 72'(irq), 72'd0);
    check("t6_tvalid", 72'(cmd_tvalid), 72'd0);

    repeat (3) tick();
    check("sb_cmd_drained", 72'(exp_cmd.size()), 72'd0);
    check("sb_rd_drained", 72'(exp_rd.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
